// File: rtl/fir_y_uart_tx.sv
// fir_y_uart_tx -- dumps the filter's output sample RAM over a UART 8N1 line.
//
// A rising edge on filt, seen while idle, starts a dump. The block reads RAM
// addresses 0..N_SAMPLES-1 and sends each 16-bit sample as two bytes, low byte
// first. Each read costs 3 cycles (address, RAM latency, latch), and tx stays
// high during those cycles.
//
// Optional feature macro: FIR_YTX_HEADER_EN. When it is defined, the block sends
// the header bytes 0xA5, 0x5A, N_SAMPLES-1 ahead of sample 0.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   filt     in   filter completion level; a rising edge starts a dump
//   ram_ra   out  [7:0]  read address into the output RAM (port B)
//   ram_dout in   [15:0] RAM read data, 1-cycle synchronous latency
//   tx       out  UART serial line, registered, idles high
//   busy     out  high from the start trigger until the last stop bit ends
//   done     out  high after a complete dump until the next start or reset
module fir_y_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int N_SAMPLES    = 172
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        filt,
   output logic [7:0]  ram_ra,
   input  logic [15:0] ram_dout,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam logic [15:0] TMR_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [7:0]  IDX_LAST = 8'(N_SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, HDR, RD, TX_LO, TX_HI, FIN} state_t;

   state_t      state, state_nxt;
   logic        filt_q, fin_q;
   logic [7:0]  idx;
   logic [15:0] shreg;      // the sample being sent; shifted right one bit per data bit
   logic [15:0] bit_tmr;
   logic [3:0]  bit_cnt;    // 0 = start bit, 1..8 = data bits, 9 = stop bit
   logic [1:0]  rd_cnt;
`ifdef FIR_YTX_HEADER_EN
   logic [1:0]  hdr_cnt;
`endif

   logic start, serialising, bit_tick, byte_end, data_bit, tx_nxt;

   assign ram_ra = idx;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef FIR_YTX_HEADER_EN
               state_nxt = HDR;
`else
               state_nxt = RD;
`endif
            end
         end
`ifdef FIR_YTX_HEADER_EN
         // Sample 0 is prefetched while the last header byte is on the line.
         // This lets its low byte follow the header with no gap.
         HDR:   if (byte_end && hdr_cnt == 2'd2) state_nxt = TX_LO;
`else
         HDR:   state_nxt = IDLE;
`endif
         RD:    if (rd_cnt == 2'd2) state_nxt = TX_LO;
         TX_LO: if (byte_end) state_nxt = TX_HI;
         TX_HI: if (byte_end) state_nxt = (idx == IDX_LAST) ? FIN : RD;
         FIN:   if (!filt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output and serialiser decode
   always_comb begin
      start       = filt & ~filt_q & (state == IDLE);
      serialising = (state == HDR) || (state == TX_LO) || (state == TX_HI);
      bit_tick    = serialising && (bit_tmr == TMR_LAST);
      byte_end    = bit_tick && (bit_cnt == 4'd9);
      data_bit    = (bit_cnt != 4'd0) && (bit_cnt != 4'd9);
      tx_nxt      = 1'b1;
      if (serialising) begin
         if (bit_cnt == 4'd0)      tx_nxt = 1'b0;
         else if (bit_cnt == 4'd9) tx_nxt = 1'b1;
         else                      tx_nxt = shreg[0];
      end
   end

   // Datapath. tx lags the state by one cycle. The lag is the same for every
   // bit, so bit widths and gaps keep their exact values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q  <= 1'b0;
         fin_q   <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         idx     <= 8'd0;
         shreg   <= 16'd0;
         bit_tmr <= 16'd0;
         bit_cnt <= 4'd0;
         rd_cnt  <= 2'd0;
`ifdef FIR_YTX_HEADER_EN
         hdr_cnt <= 2'd0;
`endif
      end else begin
         filt_q <= filt;
         tx     <= tx_nxt;
         fin_q  <= (state == FIN);

         if (start)              busy <= 1'b1;
         else if (state == FIN)  busy <= 1'b0;

         // done rises one cycle after the line has gone back to idle after the last stop bit.
         if (start)      done <= 1'b0;
         else if (fin_q) done <= 1'b1;

         if (serialising) begin
            if (bit_tick) begin
               bit_tmr <= 16'd0;
               bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
               bit_tmr <= bit_tmr + 16'd1;
            end
         end else begin
            bit_tmr <= 16'd0;
            bit_cnt <= 4'd0;
         end

         if (state == RD && rd_cnt != 2'd2) rd_cnt <= rd_cnt + 2'd1;
         else                               rd_cnt <= 2'd0;

         if (start)
            idx <= 8'd0;
         else if (state == TX_HI && byte_end && idx != IDX_LAST)
            idx <= idx + 8'd1;

         // After the 8 low-byte shifts, the high byte sits in shreg[7:0].
         if (state == RD && rd_cnt == 2'd2) shreg <= ram_dout;
         else if (bit_tick && data_bit)     shreg <= {1'b0, shreg[15:1]};
`ifdef FIR_YTX_HEADER_EN
         if (start) shreg <= 16'h00A5;
         if (state == HDR && byte_end)
            shreg <= (hdr_cnt == 2'd2) ? ram_dout
                                       : {8'h00, (hdr_cnt == 2'd0) ? 8'h5A : IDX_LAST};
         if (start)                         hdr_cnt <= 2'd0;
         else if (state == HDR && byte_end) hdr_cnt <= hdr_cnt + 2'd1;
`endif
      end
   end

endmodule

// File: tb/tb_fir_y_uart_tx.sv
module tb_fir_y_uart_tx;
   localparam int C0 = 4, N0 = 3, C1 = 7, N1 = 256, HMAX = 65536;
`ifdef FIR_YTX_HEADER_EN
   localparam int HB = 3;
`else
   localparam int HB = 0;
`endif

   logic clk = 1'b0, rst = 1'b1, filt0 = 1'b0, filt1 = 1'b0;
   logic [7:0]  ra0, ra1;
   logic [15:0] dout0, dout1;
   logic        tx0, tx1, busy0, busy1, done0, done1;
   logic [15:0] mem0 [0:255];
   logic [15:0] mem1 [0:255];

   fir_y_uart_tx #(.CLKS_PER_BIT(C0), .N_SAMPLES(N0)) u0 (
      .clk(clk), .reset(rst), .filt(filt0), .ram_ra(ra0), .ram_dout(dout0),
      .tx(tx0), .busy(busy0), .done(done0));
   fir_y_uart_tx #(.CLKS_PER_BIT(C1), .N_SAMPLES(N1)) u1 (
      .clk(clk), .reset(rst), .filt(filt1), .ram_ra(ra1), .ram_dout(dout1),
      .tx(tx1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   // synchronous-read RAM models
   always @(posedge clk) begin
      dout0 <= mem0[ra0];
      dout1 <= mem1[ra1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // per-cycle history of the lines, sampled mid-cycle
   logic h_tx0 [0:HMAX-1];
   logic h_tx1 [0:HMAX-1];
   logic h_dn1 [0:HMAX-1];
   always @(negedge clk) if (cyc < HMAX) begin
      h_tx0[cyc] <= tx0;
      h_tx1[cyc] <= tx1;
      h_dn1[cyc] <= done1;
   end

   int ntests = 0, nfail = 0;
   logic [7:0] dq[$];
   int         dt[$];
   logic [7:0] eq[$];
   int         fe;

   function automatic logic htx(input int sel, input int i);
      return (sel != 0) ? h_tx1[i] : h_tx0[i];
   endfunction

   function automatic int dump_len(input int c, input int n);
      return n * (20 * c + 3) - 3 + 1 + HB * 10 * c;
   endfunction

   // UART receiver over the recorded history: sample every bit at its centre.
   task automatic decode(input int sel, input int from, input int to);
      int c;
      logic [7:0] b;
      c = (sel != 0) ? C1 : C0;
      dq.delete(); dt.delete(); fe = 0;
      for (int i = from; i <= to; i++) begin
         if (htx(sel, i - 1) === 1'b1 && htx(sel, i) === 1'b0) begin
            if (htx(sel, i + c / 2) !== 1'b0) fe++;
            for (int k = 0; k < 8; k++) b[k] = htx(sel, i + c * (k + 1) + c / 2);
            if (htx(sel, i + c * 9 + c / 2) !== 1'b1) fe++;
            dq.push_back(b);
            dt.push_back(i);
            i = i + 10 * c - 1;
         end
      end
   endtask

   // Reference byte stream: optional header, then each sample low byte first.
   task automatic build_exp(input int sel);
      int n;
      logic [15:0] w;
      logic [7:0]  last;
      n = (sel != 0) ? N1 : N0;
      last = 8'(n - 1);
      eq.delete();
      if (HB != 0) begin
         eq.push_back(8'hA5); eq.push_back(8'h5A); eq.push_back(last);
      end
      for (int i = 0; i < n; i++) begin
         w = (sel != 0) ? mem1[i] : mem0[i];
         eq.push_back(w[7:0]);
         eq.push_back(w[15:8]);
      end
   endtask

   task automatic wait_tx_low(input int sel, input int budget, output int t, output bit ok);
      ok = 1'b0; t = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (((sel != 0) ? tx1 : tx0) === 1'b0) begin t = cyc; ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done0(input int budget, output int t, output bit ok);
      ok = 1'b0; t = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (done0 === 1'b1) begin t = cyc; ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      ntests++; if (tx0 !== 1'b1)   begin nfail++; $display("FAIL reset_tx got %b want 1", tx0); end
      ntests++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy0); end
      ntests++; if (done0 !== 1'b0) begin nfail++; $display("FAIL reset_done got %b want 0", done0); end
      ntests++; if (ra0 !== 8'd0)   begin nfail++; $display("FAIL reset_ra got %0d want 0", ra0); end
      ntests++; if (tx1 !== 1'b1)   begin nfail++; $display("FAIL reset_tx1 got %b want 1", tx1); end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic;
      int t0, td; bit ok;
      mem0[0] = 16'h1234; mem0[1] = 16'hFFFF; mem0[2] = 16'h8001;
      @(negedge clk); filt0 = 1'b1;
      @(negedge clk); filt0 = 1'b0;
      wait_tx_low(0, 100, t0, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL basic_start got no start bit want one"); return; end
      wait_done0(5000, td, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL basic_done got no done want done"); return; end
      ntests++;
      if (td - t0 !== dump_len(C0, N0)) begin
         nfail++; $display("FAIL basic_len got %0d want %0d", td - t0, dump_len(C0, N0));
      end
      ntests++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL basic_busy got %b want 0", busy0); end
      decode(0, t0, td); build_exp(0);
      ntests++;
      if (dq.size() != eq.size() || fe != 0) begin
         nfail++; $display("FAIL basic_count got %0d bytes (%0d framing errs) want %0d", dq.size(), fe, eq.size());
      end
      for (int i = 0; i < eq.size() && i < dq.size(); i++) begin
         ntests++;
         if (dq[i] !== eq[i]) begin nfail++; $display("FAIL basic_byte%0d got %h want %h", i, dq[i], eq[i]); end
      end
      repeat (20) @(negedge clk); #1;
      ntests++; if (done0 !== 1'b1) begin nfail++; $display("FAIL basic_done_hold got %b want 1", done0); end
   endtask

   task automatic test_rearm;
      int t0, td; bit ok; int lows;
      for (int i = 0; i < N0; i++) mem0[i] = 16'($urandom);
      @(negedge clk); filt0 = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (d == 1) begin
            @(negedge clk); filt0 = 1'b0;
            @(negedge clk); filt0 = 1'b1;
            @(negedge clk); #1;
            ntests++; if (done0 !== 1'b0) begin nfail++; $display("FAIL rearm_done_clear got %b want 0", done0); end
            ntests++; if (busy0 !== 1'b1) begin nfail++; $display("FAIL rearm_busy got %b want 1", busy0); end
         end
         wait_tx_low(0, 100, t0, ok);
         ntests++; if (!ok) begin nfail++; $display("FAIL rearm_start%0d got no start bit want one", d); return; end
         wait_done0(5000, td, ok);
         ntests++; if (!ok) begin nfail++; $display("FAIL rearm_done%0d got no done want done", d); return; end
         ntests++;
         if (td - t0 !== dump_len(C0, N0)) begin
            nfail++; $display("FAIL rearm_len%0d got %0d want %0d", d, td - t0, dump_len(C0, N0));
         end
         decode(0, t0, td); build_exp(0);
         ntests++;
         if (dq.size() != eq.size() || fe != 0) begin
            nfail++; $display("FAIL rearm_count%0d got %0d bytes want %0d", d, dq.size(), eq.size());
         end
         for (int i = 0; i < eq.size() && i < dq.size(); i++) begin
            ntests++;
            if (dq[i] !== eq[i]) begin nfail++; $display("FAIL rearm%0d_byte%0d got %h want %h", d, i, dq[i], eq[i]); end
         end
         if (d == 0) begin
            // filt held high: no second dump may start
            repeat (300) @(negedge clk); #1;
            lows = 0;
            for (int i = td; i < cyc; i++) if (h_tx0[i] !== 1'b1) lows++;
            ntests++; if (lows != 0) begin nfail++; $display("FAIL rearm_hold got %0d low cycles want 0", lows); end
            ntests++; if (done0 !== 1'b1) begin nfail++; $display("FAIL rearm_hold_done got %b want 1", done0); end
         end
      end
      @(negedge clk); filt0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int t0, td, tr, target, lows; bit ok;
      for (int i = 0; i < N0; i++) mem0[i] = 16'($urandom);
      @(negedge clk); filt0 = 1'b1;
      @(negedge clk); filt0 = 1'b0;
      wait_tx_low(0, 100, t0, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL rmid_start got no start bit want one"); return; end
      // middle of frame bit 4 (data bit 3) of sample 1's low byte
      target = t0 + HB * 10 * C0 + 20 * C0 + 3 + 4 * C0 + C0 / 2;
      while (cyc < target) @(negedge clk);
      #1;
      ntests++;
      if (tx0 !== mem0[1][3]) begin nfail++; $display("FAIL rmid_bit4 got %b want %b", tx0, mem0[1][3]); end
      rst = 1'b1; #1;
      ntests++; if (tx0 !== 1'b1)   begin nfail++; $display("FAIL rmid_tx got %b want 1", tx0); end
      ntests++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL rmid_busy got %b want 0", busy0); end
      ntests++; if (done0 !== 1'b0) begin nfail++; $display("FAIL rmid_done got %b want 0", done0); end
      ntests++; if (ra0 !== 8'd0)   begin nfail++; $display("FAIL rmid_ra got %0d want 0", ra0); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tr = cyc;
      repeat (300) @(negedge clk); #1;
      lows = 0;
      for (int i = tr; i < cyc; i++) if (h_tx0[i] !== 1'b1) lows++;
      ntests++; if (lows != 0) begin nfail++; $display("FAIL rmid_quiet got %0d low cycles want 0", lows); end
      ntests++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL rmid_quiet_busy got %b want 0", busy0); end
      // a fresh edge gives a complete dump from sample 0
      @(negedge clk); filt0 = 1'b1;
      @(negedge clk); filt0 = 1'b0;
      wait_tx_low(0, 100, t0, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL rmid_restart got no start bit want one"); return; end
      wait_done0(5000, td, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL rmid_redone got no done want done"); return; end
      decode(0, t0, td); build_exp(0);
      ntests++;
      if (dq.size() != eq.size() || fe != 0) begin
         nfail++; $display("FAIL rmid_count got %0d bytes want %0d", dq.size(), eq.size());
      end
      for (int i = 0; i < eq.size() && i < dq.size(); i++) begin
         ntests++;
         if (dq[i] !== eq[i]) begin nfail++; $display("FAIL rmid_byte%0d got %h want %h", i, dq[i], eq[i]); end
      end
   endtask

   task automatic test_full_range;
      int t0, td, rises, bad, ts, bi; bit ok;
      logic [7:0] ramax;
      logic [9:0] fb;
      for (int i = 0; i < N1; i++) mem1[i] = 16'(i);
      ramax = 8'd0;
      @(negedge clk); filt1 = 1'b1;
      @(negedge clk); filt1 = 1'b0;
      wait_tx_low(1, 100, t0, ok);
      ntests++; if (!ok) begin nfail++; $display("FAIL full_start got no start bit want one"); return; end
      ok = 1'b0; td = 0;
      for (int k = 0; k < 45000; k++) begin
         @(negedge clk); #1;
         if (ra1 > ramax) ramax = ra1;
         if (done1 === 1'b1) begin td = cyc; ok = 1'b1; break; end
      end
      ntests++; if (!ok) begin nfail++; $display("FAIL full_done got no done want done"); return; end
      ntests++;
      if (td - t0 !== dump_len(C1, N1)) begin
         nfail++; $display("FAIL full_len got %0d want %0d", td - t0, dump_len(C1, N1));
      end
      ntests++; if (ramax !== 8'd255) begin nfail++; $display("FAIL full_ramax got %0d want 255", ramax); end
      repeat (300) @(negedge clk); #1;
      rises = 0;
      for (int i = t0; i < cyc; i++) if (h_dn1[i] === 1'b1 && h_dn1[i - 1] !== 1'b1) rises++;
      ntests++; if (rises != 1) begin nfail++; $display("FAIL full_done_rises got %0d want 1", rises); end
      decode(1, t0, td); build_exp(1);
      ntests++;
      if (dq.size() != eq.size() || fe != 0) begin
         nfail++; $display("FAIL full_count got %0d bytes (%0d framing errs) want %0d", dq.size(), fe, eq.size());
         return;
      end
      bad = 0;
      for (int i = 0; i < eq.size(); i++) begin
         ntests++;
         if (dq[i] !== eq[i]) begin
            nfail++; bad++;
            if (bad < 10) $display("FAIL full_byte%0d got %h want %h", i, dq[i], eq[i]);
         end
      end
      ntests++;
      if (dq[dq.size() - 2] !== 8'hFF || dq[dq.size() - 1] !== 8'h00) begin
         nfail++; $display("FAIL full_last_pair got %h %h want ff 00", dq[dq.size() - 2], dq[dq.size() - 1]);
      end
      // bit timing on the 0x55 byte (low byte of sample 0x55)
      bi = HB + 2 * 8'h55;
      ts = dt[bi];
      fb = {1'b1, 8'h55, 1'b0};
      bad = 0;
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < C1; j++)
            if (h_tx1[ts + C1 * k + j] !== fb[k]) bad++;
      ntests++; if (bad != 0) begin nfail++; $display("FAIL bit_width got %0d off cycles want 0", bad); end
      ntests++; if (h_tx1[ts - 1] !== 1'b1) begin nfail++; $display("FAIL bit_lead got %b want 1", h_tx1[ts - 1]); end
      ntests++; if (h_tx1[ts + 3] !== 1'b0) begin nfail++; $display("FAIL start_bit got %b want 0", h_tx1[ts + 3]); end
      ntests++;
      if (h_tx1[ts + 9 * C1 + 3] !== 1'b1) begin nfail++; $display("FAIL stop_bit got %b want 1", h_tx1[ts + 9 * C1 + 3]); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin mem0[i] = 16'd0; mem1[i] = 16'd0; end
      test_reset;
      test_basic;
      test_rearm;
      test_reset_mid;
      test_full_range;
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
